text_grid_buffer: RTL and testbench

TEXT_GRID_BUFFER -- requirements
Module: text_grid_buffer

---
 rtl/text_grid_buffer.sv | 169 ++++++++++++++++
 tb/tb_text_grid_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_grid_buffer.sv
// Character grid with a write cursor, terminal-style control codes, one random read port and fixed tap cells.
// Latency: rd_data, tap_data and the cursor are registered, so each reflects the previous edge (read-before-write).
// Backpressure: wr_ready drops while the grid is being cleared or when clear_req is raised; offered characters then wait.
module text_grid_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 4,
    parameter int                    COLS       = 32,
    parameter int                    TAPS       = 2,
    parameter logic [DATA_WIDTH-1:0] BLANK      = DATA_WIDTH'(8'h20)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_ready,
    input  logic                       clear_req,
    input  logic [$clog2(ROWS)-1:0]    rd_row,
    input  logic [$clog2(COLS)-1:0]    rd_col,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [TAPS*DATA_WIDTH-1:0] tap_data,
    output logic [$clog2(ROWS)-1:0]    cur_row,
    output logic [$clog2(COLS)-1:0]    cur_col,
    output logic                       busy
);
    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int IW    = $clog2(CELLS);

    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           sweep_q, sweep_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [TAPS*DATA_WIDTH-1:0] tap_q;
    logic [DATA_WIDTH-1:0]   mem_q [CELLS];

    logic                    mem_we;
    logic [IW-1:0]           mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [7:0]              code;
    logic [IW-1:0]           cur_idx;
    logic [RW-1:0]           row_inc;
    logic                    rd_in_range;
    logic [IW-1:0]           rd_idx;

    // Only the low byte selects control behaviour; wider cells still store every bit.
    assign code        = wr_data[7:0];
    assign cur_idx     = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign row_inc     = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    assign rd_in_range = (rd_row <= ROW_LAST) && (rd_col <= COL_LAST);
    assign rd_idx      = IW'(rd_row) * IW'(COLS) + IW'(rd_col);

    assign wr_ready = (state_q == S_IDLE) && !clear_req;
    assign busy     = (state_q == S_CLEAR);
    assign rd_data  = rd_data_q;
    assign tap_data = tap_q;
    assign cur_row  = row_q;
    assign cur_col  = col_q;

    // Next-state logic: sweep blanking in CLEAR, cursor movement and the single cell write in IDLE.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        row_d     = row_q;
        col_d     = col_q;
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wdata = BLANK;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                if (sweep_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (wr_valid) begin
                    case (code)
                        CODE_CR: col_d = '0;
                        CODE_LF: begin
                            col_d = '0;
                            row_d = row_inc;
                        end
                        CODE_BS: begin
                            // At column 0 backspace is a no-op; it never reaches into the previous row.
                            if (col_q != '0) begin
                                col_d     = col_q - 1'b1;
                                mem_we    = 1'b1;
                                mem_waddr = cur_idx - 1'b1;
                            end
                        end
                        default: begin
                            mem_we    = 1'b1;
                            mem_waddr = cur_idx;
                            mem_wdata = wr_data;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_inc;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Control state: reset restarts the blanking sweep from the first cell and homes the cursor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Cell storage: a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port and taps sample the array before this edge's write lands; out-of-range reads give zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
            tap_q     <= '0;
        end else begin
            rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem_q[k];
            end
        end
    end

endmodule

// File: tb/tb_text_grid_buffer.sv
// Bench for text_grid_buffer: default 4x32 grid plus a 3x5, 12-bit grid for out-of-range reads and wide cells.
// Stimulus pushes expectations tagged with the cycle they must hold; a negedge monitor pops and compares.
// Every expected value is a hand-computed constant.
module tb_text_grid_buffer;

    localparam int K_RD   = 0;
    localparam int K_TAP  = 1;
    localparam int K_CUR  = 2;
    localparam int K_BUSY = 3;
    localparam int K_RDY  = 4;
    localparam int K_RD2  = 5;
    localparam int K_TAP2 = 6;
    localparam int K_CUR2 = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, clear_req, wr_ready, busy;
    logic [7:0]  wr_data, rd_data;
    logic [1:0]  rd_row, cur_row;
    logic [4:0]  rd_col, cur_col;
    logic [15:0] tap_data;

    logic        wr_valid2, clear_req2, wr_ready2, busy2;
    logic [11:0] wr_data2, rd_data2, tap_data2;
    logic [1:0]  rd_row2, cur_row2;
    logic [2:0]  rd_col2, cur_col2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    text_grid_buffer #(
        .DATA_WIDTH(8), .ROWS(4), .COLS(32), .TAPS(2), .BLANK(8'h20)
    ) u_dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .clear_req(clear_req),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .tap_data(tap_data),
        .cur_row(cur_row), .cur_col(cur_col),
        .busy(busy)
    );

    text_grid_buffer #(
        .DATA_WIDTH(12), .ROWS(3), .COLS(5), .TAPS(1), .BLANK(12'h020)
    ) u_small (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid2), .wr_data(wr_data2), .wr_ready(wr_ready2),
        .clear_req(clear_req2),
        .rd_row(rd_row2), .rd_col(rd_col2), .rd_data(rd_data2),
        .tap_data(tap_data2),
        .cur_row(cur_row2), .cur_col(cur_col2),
        .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int k);
        case (k)
            K_RD:    return 32'(rd_data);
            K_TAP:   return 32'(tap_data);
            K_CUR:   return 32'({cur_row, cur_col});
            K_BUSY:  return 32'(busy);
            K_RDY:   return 32'(wr_ready);
            K_RD2:   return 32'(rd_data2);
            K_TAP2:  return 32'(tap_data2);
            K_CUR2:  return 32'({cur_row2, cur_col2});
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle, flag any that were skipped.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = actual(sb[i].kind);
                n_cmp++;
                if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: never compared (due cycle %0d, now %0d), expected 0x%0h", sb[i].name, sb[i].cyc, cyc, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int dly, int kind, logic [31:0] e, string nm);
        exp_t x;
        x.cyc  = cyc + dly;
        x.kind = kind;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic wr(logic [7:0] c);
        wr_valid = 1'b1;
        wr_data  = c;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(int r, int c, logic [7:0] e, string nm);
        rd_row = 2'(r);
        rd_col = 5'(c);
        push(1, K_RD, 32'(e), nm);
        step();
    endtask

    task automatic rd2(int r, int c, logic [11:0] e, string nm);
        rd_row2 = 2'(r);
        rd_col2 = 3'(c);
        push(1, K_RD2, 32'(e), nm);
        step();
    endtask

    // Expects the sweep to be in progress now and to last exactly 128 cycles; optionally pokes clear_req mid-way.
    task automatic wait_sweep(int inject_at);
        for (int i = 0; i < 128; i++) begin
            push(0, K_BUSY, 32'd1, "sweep_busy");
            push(0, K_RDY, 32'd0, "sweep_wr_ready_low");
            clear_req = (i == inject_at);
            step();
        end
        clear_req = 1'b0;
        push(0, K_BUSY, 32'd0, "sweep_ends_after_128");
        push(0, K_RDY, 32'd1, "wr_ready_after_sweep");
    endtask

    function automatic logic [31:0] cur1(int r, int c);
        return 32'(r * 32 + c);
    endfunction

    initial begin
        reset = 1'b1;
        wr_valid = 1'b0; wr_data = '0; clear_req = 1'b0; rd_row = '0; rd_col = '0;
        wr_valid2 = 1'b0; wr_data2 = '0; clear_req2 = 1'b0; rd_row2 = '0; rd_col2 = '0;
        step();
        step();
        push(0, K_RD, 32'h0, "reset_rd_data");
        push(0, K_TAP, 32'h0, "reset_tap_data");
        push(0, K_BUSY, 32'd1, "reset_busy");
        push(0, K_CUR, 32'h0, "reset_cursor");
        push(0, K_RDY, 32'd0, "reset_wr_ready");
        push(0, K_RD2, 32'h0, "reset_rd_data_small");
        reset = 1'b0;
        wait_sweep(-1);

        // Every cell blank after the first sweep.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                rd(r, c, 8'h20, "blank_cell");
        push(0, K_TAP, 32'h2020, "blank_tap");

        // Small grid: wide cells keep upper bits, classification uses the low byte, out-of-range reads give 0.
        push(0, K_CUR2, 32'h0, "small_cursor_home");
        wr_valid2 = 1'b1; wr_data2 = 12'hA41;
        step();
        push(0, K_CUR2, 32'h1, "small_cursor_after_char");
        wr_data2 = 12'h30D;
        step();
        wr_valid2 = 1'b0;
        push(0, K_CUR2, 32'h0, "small_cr_with_high_bits");
        push(0, K_TAP2, 32'hA41, "small_tap_wide");
        rd2(0, 0, 12'hA41, "small_wide_cell");
        rd2(0, 1, 12'h020, "small_cr_not_stored");
        rd2(3, 0, 12'h000, "small_oob_row");
        rd2(0, 5, 12'h000, "small_oob_col5");
        rd2(0, 7, 12'h000, "small_oob_col7");
        rd2(2, 4, 12'h020, "small_last_cell");

        // "AB", CR, "C".
        push(0, K_CUR, cur1(0, 0), "cursor_before_AB");
        wr(8'h41);
        wr(8'h42);
        push(0, K_CUR, cur1(0, 2), "cursor_after_AB");
        wr(8'h0D);
        push(0, K_CUR, cur1(0, 0), "cursor_after_cr");
        wr(8'h43);
        push(0, K_CUR, cur1(0, 1), "cursor_after_C");
        step();
        push(0, K_TAP, 32'h4243, "tap_after_AB_cr_C");
        rd(0, 0, 8'h43, "cell00_C");
        rd(0, 1, 8'h42, "cell01_B");
        rd(0, 2, 8'h20, "cell02_blank");

        // "XY", then three backspaces.
        wr(8'h0D);
        wr(8'h58);
        wr(8'h59);
        push(0, K_CUR, cur1(0, 2), "cursor_after_XY");
        wr(8'h08);
        push(0, K_CUR, cur1(0, 1), "cursor_after_bs1");
        wr(8'h08);
        push(0, K_CUR, cur1(0, 0), "cursor_after_bs2");
        wr(8'h08);
        push(0, K_CUR, cur1(0, 0), "bs_at_col0_no_move");
        rd(0, 0, 8'h20, "bs_blanked_00");
        rd(0, 1, 8'h20, "bs_blanked_01");
        rd(3, 31, 8'h20, "bs_col0_no_wrap_write");

        // Read-before-write on (0,0), tap follows the same rule.
        rd_row = 2'd0; rd_col = 5'd0;
        wr_valid = 1'b1; wr_data = 8'h51;
        push(1, K_RD, 32'h20, "rbw_old_value");
        push(1, K_TAP, 32'h2020, "rbw_tap_old");
        step();
        wr_valid = 1'b0;
        push(0, K_CUR, cur1(0, 1), "cursor_after_Q");
        push(1, K_RD, 32'h51, "rbw_new_value");
        push(1, K_TAP, 32'h2051, "rbw_tap_new");
        step();

        // Fill row 3 and wrap to the origin.
        wr(8'h0D);
        wr(8'h0A);
        wr(8'h0A);
        wr(8'h0A);
        push(0, K_CUR, cur1(3, 0), "cursor_row3");
        for (int i = 0; i < 32; i++) wr(8'h41);
        push(0, K_CUR, cur1(0, 0), "cursor_wraps_to_origin");
        for (int c = 0; c < 32; c++) rd(3, c, 8'h41, "row3_filled");
        rd(2, 0, 8'h20, "row2_untouched");
        rd(0, 0, 8'h51, "row0_not_overwritten");

        // LF moves to column 0 of the next row and wraps from the last row.
        wr(8'h4D);
        wr(8'h0A);
        push(0, K_CUR, cur1(1, 0), "lf_next_row_col0");
        wr(8'h0A);
        wr(8'h0A);
        push(0, K_CUR, cur1(3, 0), "lf_row3");
        wr(8'h0A);
        push(0, K_CUR, cur1(0, 0), "lf_wraps_row0");

        // clear_req wins over a coincident character; a second request mid-sweep is ignored.
        wr(8'h4E);
        push(0, K_CUR, cur1(0, 1), "cursor_before_clear");
        clear_req = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A;
        rd_row = 2'd0; rd_col = 5'd1;
        push(0, K_RDY, 32'd0, "wr_ready_low_with_clear");
        push(1, K_RD, 32'h20, "clear_edge_read_old");
        push(2, K_RD, 32'h20, "char_on_clear_not_stored");
        push(1, K_CUR, cur1(0, 0), "clear_homes_cursor");
        step();
        clear_req = 1'b0; wr_valid = 1'b0;
        wait_sweep(60);
        rd(0, 0, 8'h20, "cleared_cell00");
        push(0, K_TAP, 32'h2020, "cleared_tap");
        rd(3, 5, 8'h20, "cleared_row3");

        // Write on a reset edge is dropped; reset mid-sweep restarts the full sweep.
        wr(8'h50);
        push(0, K_CUR, cur1(0, 1), "cursor_before_reset");
        reset = 1'b1; wr_valid = 1'b1; wr_data = 8'h4B;
        rd_row = 2'd0; rd_col = 5'd1;
        push(1, K_RD, 32'h0, "reset_clears_rd_data");
        push(2, K_RD, 32'h20, "write_on_reset_dropped");
        push(1, K_CUR, cur1(0, 0), "reset_homes_cursor");
        step();
        reset = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        push(0, K_BUSY, 32'd1, "busy_mid_sweep");
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_sweep(-1);
        rd(0, 0, 8'h20, "final_cell00");
        rd(3, 31, 8'h20, "final_cell_last");

        repeat (3) step();
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            n_cmp++;
            n_bad++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
